inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
Streaming RISC-V instruction encoder. It is the inverse of the core's immediate generator: it takes decoded fields plus a signed 32-bit immediate and packs them into 32-bit instruction words. It range-checks the immediate and tags each word with an instruction-memory write address. It sits between the test/program loader and instruction memory, and feeds the round-trip checks against the immediate generator.

Parameters:
ADDR_W, 32, width of the output word address.
BASE_ADDR, 32'h0000_0000, first address emitted after reset or clear; must be 4-byte aligned.
DEPTH, 2, output buffer entries (power of two, ≥2).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
clear  in  1  synchronous flush: empties buffer, reloads address, zeroes err_count.
in_valid  in  1  input fields valid.
in_ready  out  1  encoder can accept this cycle.
fmt  in  3  format: 0=I, 1=I_SHIFT, 2=S, 3=U, 4=B; 5–7 illegal.
opcode  in  7  opcode, passed through to inst[6:0].
funct3  in  3  passed through to inst[14:12] (ignored for U).
funct7  in  7  used only by I_SHIFT, as inst[31:25].
rd, rs1, rs2  in  5 each  register indices; used per format.
imm  in  32  signed immediate, byte offset for B.
out_valid  out  1  buffer head valid.
out_ready  in  1  consumer accepts head.
inst  out  32  encoded instruction.
addr  out  ADDR_W  word address for inst.
err  out  1  head word had an encoding violation.
err_count  out  8  saturating count of accepted words with err=1.

Behaviour:
- Reset (rst_n low, async): buffer empty, out_valid=0, inst=0, addr=BASE_ADDR, err=0, err_count=0, next-address register=BASE_ADDR.
- Handshakes:
  - Accept when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - in_ready = (count != DEPTH) && !clear. It does not depend on out_ready (no combinational path from out_ready to in_ready).
- Latency: a word accepted at edge N appears at the head after edge N if the buffer was empty. Otherwise it is strictly FIFO-ordered.
- Accept and pop in the same cycle: count unchanged. With count=DEPTH, in_ready is already low.
- Address: each accepted word is tagged with the next-address register, which then advances by 4. It wraps modulo 2^ADDR_W.
- Encoding (computed combinationally at accept, stored in the buffer):
  - I: {imm[11:0], rs1, funct3, rd, opcode}. Legal when -2048 ≤ imm ≤ 2047.
  - I_SHIFT: {funct7, imm[4:0], rs1, funct3, rd, opcode}. Legal when 0 ≤ imm ≤ 31.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}. Range as I.
  - U: {imm[31:12], rd, opcode}. Legal when imm[11:0] == 0.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}. Legal when -4096 ≤ imm ≤ 4094 and imm[0] == 0.
  - fmt 5–7: inst = 32'h0, err = 1.
- Violation handling: the word is still emitted with truncated fields as listed and err=1. err_count increments on accept and saturates at 255.
- clear: takes priority over accept and pop in that cycle. The buffer empties (out_valid=0 next cycle), next address = BASE_ADDR, err_count = 0.
- Reset mid-stream: all buffered words are discarded. Nothing is replayed.
- Round-trip invariant: for every emitted word with err=0 and fmt in {I, S, U, B}, feeding inst to the immediate generator returns imm exactly. For I_SHIFT it returns {27'b0, imm[4:0]}.
- inst, addr and err are don't-care while out_valid=0, but must be held stable while out_valid && !out_ready.

Decomposition:
- Shared package riscv_enc_pkg holds:
  - typedef enum logic [2:0] fmt_e (FMT_I, FMT_ISHIFT, FMT_S, FMT_U, FMT_B);
  - opcode constants OP_LOAD=7'b0000011, OP_IMM=7'b0010011, OP_STORE=7'b0100011, OP_LUI=7'b0110111, OP_BRANCH=7'b1100011;
  - a packed struct for buffer entries {inst, addr, err}.
- One sub-module, enc_fifo, holds the DEPTH-entry buffer with count, pointers and the valid/ready logic. Encoding and range check stay in the top module.

Test Plan:
- Branch: fmt=B, opcode=OP_BRANCH, rs1=4, rs2=3, funct3=0, imm=8 → inst=32'h00320463, addr=BASE_ADDR, err=0; the immediate generator returns 8.
- Load: fmt=I, OP_LOAD, rd=5, rs1=2, funct3=3'b010, imm=-4 → 32'hFFC12283. Store: fmt=S, OP_STORE, rs1=1, rs2=6, funct3=3'b010, imm=12 → 32'h0060A623 at addr+4.
- LUI: fmt=U, rd=7, imm=32'h12345000 → 32'h123453B7, err=0. The same with imm=32'h12345001 → err=1, err_count=1.
- Shift: fmt=I_SHIFT, funct7=7'b0100000, rd=1, rs1=2, funct3=3'b101, imm=3 → 32'h40315093.
- B-format violations: imm=5 → err=1; imm=4096 → err=1; fmt=6 → inst=0, err=1. err_count increments once per word, and saturates at 255 after 300 illegal words.
- Backpressure and control: hold out_ready=0 for 3 words → in_ready drops after 2 (DEPTH=2), head stays stable, order is preserved on release. Mid-stream clear → out_valid=0 next cycle and the next word gets addr=BASE_ADDR. Async rst_n pulse clears everything; addr wrap is checked with ADDR_W=4.

Source files
------------

// File: rtl/inst_encoder_pkg.sv
// Shared types and constants for the RISC-V instruction encoder.
package riscv_enc_pkg;

  typedef enum logic [2:0] {
    FMT_I      = 3'd0,
    FMT_ISHIFT = 3'd1,
    FMT_S      = 3'd2,
    FMT_U      = 3'd3,
    FMT_B      = 3'd4
  } fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Address is stored at full width; the top narrows it to ADDR_W (<= 32).
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
  } enc_entry_t;

endpackage

// File: rtl/inst_encoder_if.sv
// Field input / encoded word output bundle of the instruction encoder.
interface inst_encoder_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        fmt;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [31:0]       imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       inst;
  logic [ADDR_W-1:0] addr;
  logic              err;
  logic [7:0]        err_count;

  modport master (
    output in_valid, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm, out_ready,
    input  in_ready, out_valid, inst, addr, err, err_count
  );

  modport slave (
    input  in_valid, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm, out_ready,
    output in_ready, out_valid, inst, addr, err, err_count
  );
endinterface

// File: rtl/inst_encoder_fifo.sv
// DEPTH-entry FIFO of encoded words; clear takes priority over push and pop.
module enc_fifo
  import riscv_enc_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       wr_en,
  input  enc_entry_t wr_data,
  input  logic       rd_en,
  output enc_entry_t rd_data,
  output logic       empty,
  output logic       full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  enc_entry_t      mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  // NOTE: state registers use <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage has no reset; emptiness comes from count and the top masks the head.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
endmodule

// File: rtl/inst_encoder.sv
// Packs decoded RISC-V fields and an immediate into instruction words,
// range-checks the immediate and tags each word with an imem address.
module inst_encoder
  import riscv_enc_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                DEPTH     = 2
) (
  input logic           clk,
  input logic           rst_n,
  input logic           clear,
  inst_encoder_if.slave bus
);
  logic signed [31:0] simm;
  fmt_e               fmt_sel;
  logic [31:0]        enc_inst;
  logic               enc_err;
  logic               accept;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ADDR_W-1:0]  next_addr;
  logic [7:0]         err_cnt;
  enc_entry_t         wr_entry;
  enc_entry_t         head;

  assign simm    = $signed(bus.imm);
  assign fmt_sel = fmt_e'(bus.fmt);

  // NOTE: defaults first so no path through this block can infer a latch.
  always_comb begin
    enc_inst = '0;
    enc_err  = 1'b0;
    case (fmt_sel)
      FMT_I: begin
        enc_inst = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
        enc_err  = (simm < -2048) || (simm > 2047);
      end
      FMT_ISHIFT: begin
        enc_inst = {bus.funct7, bus.imm[4:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
        enc_err  = (simm < 0) || (simm > 31);
      end
      FMT_S: begin
        enc_inst = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.opcode};
        enc_err  = (simm < -2048) || (simm > 2047);
      end
      FMT_U: begin
        enc_inst = {bus.imm[31:12], bus.rd, bus.opcode};
        enc_err  = (bus.imm[11:0] != 12'h000);
      end
      FMT_B: begin
        enc_inst = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                    bus.imm[4:1], bus.imm[11], bus.opcode};
        enc_err  = (simm < -4096) || (simm > 4094) || bus.imm[0];
      end
      default: enc_err = 1'b1;
    endcase
  end

  assign bus.in_ready = !fifo_full && !clear;
  assign accept       = bus.in_valid && bus.in_ready;
  assign pop          = bus.out_valid && bus.out_ready;

  assign wr_entry = '{inst: enc_inst, addr: 32'(next_addr), err: enc_err};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_addr <= BASE_ADDR;
      err_cnt   <= '0;
    end else if (clear) begin
      next_addr <= BASE_ADDR;
      err_cnt   <= '0;
    end else if (accept) begin
      next_addr <= next_addr + ADDR_W'(4);
      if (enc_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  enc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .wr_en   (accept),
    .wr_data (wr_entry),
    .rd_en   (pop && !clear),
    .rd_data (head),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // Empty head reads as the reset word rather than stale storage.
  assign bus.out_valid = !fifo_empty;
  assign bus.inst      = fifo_empty ? 32'h0 : head.inst;
  assign bus.addr      = fifo_empty ? BASE_ADDR : head.addr[ADDR_W-1:0];
  assign bus.err       = fifo_empty ? 1'b0 : head.err;
  assign bus.err_count = err_cnt;
endmodule

// File: tb/tb_inst_encoder.sv
// Randomized + directed bench for inst_encoder against an arithmetic model
// and an independent immediate-generator round-trip.
module tb_inst_encoder;
  import riscv_enc_pkg::*;

  localparam int              ADDR_W = 4;
  localparam logic [ADDR_W-1:0] BASE = 4'h4;
  localparam int              DEPTH  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;

  inst_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  inst_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]       inst;
    logic [ADDR_W-1:0] addr;
    logic              err;
    int                fmt;
    int                imm;
  } exp_t;

  exp_t              q[$];
  logic [ADDR_W-1:0] m_next;
  int                m_errcnt;
  int                checks = 0;
  int                errors = 0;
  int                bnd[13] = '{-4097, -4096, -2049, -2048, -1, 0, 31, 32,
                                 2047, 2048, 4094, 4095, 4096};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_encode(input int f, input logic [31:0] op, input logic [31:0] f3,
                                     input logic [31:0] f7, input logic [31:0] rd,
                                     input logic [31:0] rs1, input logic [31:0] rs2,
                                     input int imm, output logic [31:0] w, output logic e);
    logic [31:0] u;
    u = imm;
    case (f)
      0: begin
        w = op | (rd << 7) | (f3 << 12) | (rs1 << 15) | ((u & 32'hFFF) << 20);
        e = (imm < -2048) || (imm > 2047);
      end
      1: begin
        w = op | (rd << 7) | (f3 << 12) | (rs1 << 15) | ((u & 31) << 20) | (f7 << 25);
        e = (imm < 0) || (imm > 31);
      end
      2: begin
        w = op | ((u & 31) << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20) | (((u >> 5) & 127) << 25);
        e = (imm < -2048) || (imm > 2047);
      end
      3: begin
        w = op | (rd << 7) | (u & 32'hFFFF_F000);
        e = (u & 32'hFFF) != 0;
      end
      4: begin
        w = op | (((u >> 11) & 1) << 7) | (((u >> 1) & 15) << 8) | (f3 << 12) | (rs1 << 15)
               | (rs2 << 20) | (((u >> 5) & 63) << 25) | (((u >> 12) & 1) << 31);
        e = (imm < -4096) || (imm > 4094) || (imm % 2 != 0);
      end
      default: begin
        w = 32'h0;
        e = 1'b1;
      end
    endcase
  endfunction

  // Immediate generator as the core decodes it, used for round-trip checks.
  function automatic int imm_gen(input logic [31:0] w, input int f);
    case (f)
      0:       return int'({{20{w[31]}}, w[31:20]});
      1:       return int'({27'b0, w[24:20]});
      2:       return int'({{20{w[31]}}, w[31:25], w[11:7]});
      3:       return int'({w[31:12], 12'b0});
      default: return int'({{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0});
    endcase
  endfunction

  task automatic set_f(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
    bus.fmt = f; bus.opcode = op; bus.funct3 = f3; bus.funct7 = f7;
    bus.rd = rd; bus.rs1 = rs1; bus.rs2 = rs2; bus.imm = imm;
  endtask

  task automatic rand_fields(input bit legal_fmt);
    int imm_v;
    if (!legal_fmt && $urandom_range(0, 9) == 0) bus.fmt = 3'($urandom_range(5, 7));
    else bus.fmt = 3'($urandom_range(0, 4));
    bus.opcode = 7'($urandom); bus.funct3 = 3'($urandom); bus.funct7 = 7'($urandom);
    bus.rd = 5'($urandom); bus.rs1 = 5'($urandom); bus.rs2 = 5'($urandom);
    case ($urandom_range(0, 3))
      0:       imm_v = int'($urandom_range(0, 8191)) - 4096;
      1:       imm_v = bnd[$urandom_range(0, 12)];
      2:       imm_v = int'($urandom);
      default: imm_v = int'($urandom & 32'hFFFF_F000);
    endcase
    if (bus.fmt == 3'd1 && $urandom_range(0, 1) == 1) imm_v = int'($urandom_range(0, 31));
    bus.imm = imm_v;
  endtask

  // Starts and ends on a falling edge; checks outputs, then advances the model.
  task automatic cycle(input logic v, input logic ordy, input logic clr);
    logic [31:0] w;
    logic        e;
    bit          acc;
    bit          popped;
    bus.in_valid = v; bus.out_ready = ordy; clear = clr;
    #1;
    check("out_valid", bus.out_valid, q.size() > 0);
    check("in_ready", bus.in_ready, (q.size() < DEPTH) && !clr);
    check("err_count", bus.err_count, m_errcnt);
    if (q.size() > 0) begin
      check("inst", bus.inst, q[0].inst);
      check("addr", bus.addr, q[0].addr);
      check("err", bus.err, q[0].err);
      if (!q[0].err)
        check("roundtrip", imm_gen(bus.inst, q[0].fmt), (q[0].fmt == 1) ? (q[0].imm & 31) : q[0].imm);
    end
    if (clr) begin
      q.delete(); m_next = BASE; m_errcnt = 0;
    end else begin
      acc    = v && (q.size() < DEPTH);
      popped = ordy && (q.size() > 0);
      if (popped) void'(q.pop_front());
      if (acc) begin
        ref_encode(int'(bus.fmt), bus.opcode, bus.funct3, bus.funct7, bus.rd, bus.rs1, bus.rs2,
                   int'(bus.imm), w, e);
        q.push_back('{inst: w, addr: m_next, err: e, fmt: int'(bus.fmt), imm: int'(bus.imm)});
        m_next += 4;
        if (e && m_errcnt < 255) m_errcnt++;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0; clear = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_inst", bus.inst, 32'h0);
    check("rst_addr", bus.addr, BASE);
    check("rst_err", bus.err, 1'b0);
    check("rst_err_count", bus.err_count, 8'd0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    q.delete(); m_next = BASE; m_errcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Single word through an empty buffer, with literal expectations.
  task automatic directed(input string tag, input logic [31:0] exp_inst,
                          input logic [ADDR_W-1:0] exp_addr, input logic exp_err);
    cycle(1'b1, 1'b0, 1'b0);
    check({tag, "_inst"}, bus.inst, exp_inst);
    check({tag, "_addr"}, bus.addr, exp_addr);
    check({tag, "_err"}, bus.err, exp_err);
    cycle(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    set_f(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    @(negedge clk);
    do_reset();

    set_f(FMT_B, OP_BRANCH, 3'd0, 7'd0, 5'd0, 5'd4, 5'd3, 32'd8);
    directed("branch", 32'h0032_0463, 4'h4, 1'b0);
    set_f(FMT_I, OP_LOAD, 3'b010, 7'd0, 5'd5, 5'd2, 5'd0, -32'sd4);
    directed("load", 32'hFFC1_2283, 4'h8, 1'b0);
    set_f(FMT_S, OP_STORE, 3'b010, 7'd0, 5'd0, 5'd1, 5'd6, 32'd12);
    directed("store", 32'h0060_A623, 4'hC, 1'b0);
    set_f(FMT_U, OP_LUI, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 32'h1234_5000);
    directed("lui", 32'h1234_53B7, 4'h0, 1'b0);
    set_f(FMT_U, OP_LUI, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 32'h1234_5001);
    directed("lui_bad", 32'h1234_53B7, 4'h4, 1'b1);
    check("lui_bad_err_count", bus.err_count, 8'd1);
    set_f(FMT_ISHIFT, OP_IMM, 3'b101, 7'b0100000, 5'd1, 5'd2, 5'd0, 32'd3);
    directed("shift", 32'h4031_5093, 4'h8, 1'b0);
    set_f(FMT_B, OP_BRANCH, 3'd0, 7'd0, 5'd0, 5'd4, 5'd3, 32'd5);
    directed("b_odd", 32'h0032_0263, 4'hC, 1'b1);
    set_f(FMT_B, OP_BRANCH, 3'd0, 7'd0, 5'd0, 5'd4, 5'd3, 32'd4096);
    directed("b_far", 32'h8032_0063, 4'h0, 1'b1);
    set_f(3'd6, OP_BRANCH, 3'd0, 7'd0, 5'd0, 5'd4, 5'd3, 32'd8);
    directed("fmt6", 32'h0, 4'h4, 1'b1);
    check("viol_err_count", bus.err_count, 8'd4);

    // Saturation of the error counter, then clear.
    bus.fmt = 3'd7;
    repeat (300) cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    check("sat_err_count", bus.err_count, 8'd255);
    cycle(1'b0, 1'b0, 1'b1);
    check("clr_err_count", bus.err_count, 8'd0);
    check("clr_out_valid", bus.out_valid, 1'b0);

    // Backpressure: third word is refused while the buffer is full.
    rand_fields(1); cycle(1'b1, 1'b0, 1'b0);
    rand_fields(1); cycle(1'b1, 1'b0, 1'b0);
    check("bp_in_ready", bus.in_ready, 1'b0);
    rand_fields(1); cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b1, 1'b0);

    // Mid-stream clear, with in_valid held high during the clear.
    rand_fields(1); cycle(1'b1, 1'b0, 1'b0);
    rand_fields(1); cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    check("mid_clr_out_valid", bus.out_valid, 1'b0);
    rand_fields(1); cycle(1'b1, 1'b0, 1'b0);
    check("mid_clr_addr", bus.addr, BASE);
    repeat (2) cycle(1'b0, 1'b1, 1'b0);

    // Asynchronous reset pulse with words buffered.
    rand_fields(0); cycle(1'b1, 1'b0, 1'b0);
    rand_fields(0); cycle(1'b1, 1'b0, 1'b0);
    do_reset();
    cycle(1'b0, 1'b1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      rand_fields(0);
      if ($urandom_range(0, 299) == 0) do_reset();
      else cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
    end
    repeat (3) cycle(1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
